// File: rtl/data_sync_ctrl.sv
// Destination-domain sequencer for a 4-phase req/ack bus synchronizer: syncs req, waits a settle
// window, pulses SEL for one capture cycle, then strobes enable_pulse and holds ack until release.
module data_sync_ctrl #(
    parameter int unsigned NUM_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_async,
    output logic                 SEL,
    output logic                 enable_pulse,
    output logic                 ack,
    output logic                 busy,
    output logic                 abort_err,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SetW-1:0] SettleLast =
        SetW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StAck} state_e;

    state_e                state_q, state_d;
    logic [SetW-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] sync_q;
    logic                  req_s;
    logic                  abort_d;
    logic                  sel_q, en_q, ack_q, busy_q, abort_q;
    logic [CNT_WIDTH-1:0]  xfer_q;

    assign req_s = sync_q[NUM_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], req_async};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req_s) begin
                    state_d = (SETTLE_CYCLES > 0) ? StSettle : StCapture;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 1'b1;
                // A withdrawn request wins over the terminal count.
                if (!req_s) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (cnt_q == SettleLast) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StAck;
            StAck: begin
                if (!req_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= (state_d == StCapture);
            en_q    <= (state_q == StCapture);
            ack_q   <= (state_d == StAck);
            busy_q  <= (state_d != StIdle);
            abort_q <= abort_d;
            if (state_q == StCapture) begin
                xfer_q <= xfer_q + 1'b1;
            end
        end
    end

    assign SEL          = sel_q;
    assign enable_pulse = en_q;
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign abort_err    = abort_q;
    assign xfer_cnt     = xfer_q;

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Bench for data_sync_ctrl: three parameterisations share one req/reset stream and are compared
// every cycle against a transfer-age model, plus directed latency and handshake checks.
module tb_data_sync_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req_async;
    logic       sel_w[3], en_w[3], ack_w[3], busy_w[3], abort_w[3];
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    logic [7:0] src_bus, bus_q;

    int n_asserts = 0;
    int n_fail    = 0;

    int sp[3] = '{1, 3, 0};
    int ns[3] = '{2, 2, 2};
    int cw[3] = '{8, 2, 8};

    // Model: each instance tracks a delayed copy of req and the age of the current transfer.
    int sh[3][8];
    bit m_busy[3];
    int m_age[3];
    bit m_abort[3];
    int m_cnt[3];
    int sel_seen[3], en_seen[3], ab_seen[3];

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) if (sel_w[0]) bus_q <= src_bus;

    data_sync_ctrl #(.NUM_STAGES(2), .SETTLE_CYCLES(1), .CNT_WIDTH(8)) dut_a (
        .CLK(CLK), .RST(RST), .req_async(req_async), .SEL(sel_w[0]), .enable_pulse(en_w[0]),
        .ack(ack_w[0]), .busy(busy_w[0]), .abort_err(abort_w[0]), .xfer_cnt(cnt_a)
    );
    data_sync_ctrl #(.NUM_STAGES(2), .SETTLE_CYCLES(3), .CNT_WIDTH(2)) dut_b (
        .CLK(CLK), .RST(RST), .req_async(req_async), .SEL(sel_w[1]), .enable_pulse(en_w[1]),
        .ack(ack_w[1]), .busy(busy_w[1]), .abort_err(abort_w[1]), .xfer_cnt(cnt_b)
    );
    data_sync_ctrl #(.NUM_STAGES(2), .SETTLE_CYCLES(0), .CNT_WIDTH(8)) dut_c (
        .CLK(CLK), .RST(RST), .req_async(req_async), .SEL(sel_w[2]), .enable_pulse(en_w[2]),
        .ack(ack_w[2]), .busy(busy_w[2]), .abort_err(abort_w[2]), .xfer_cnt(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!RST) begin
                for (int k = 0; k < 8; k++) sh[i][k] = 0;
                m_busy[i] = 0; m_age[i] = 0; m_abort[i] = 0; m_cnt[i] = 0;
            end else begin
                int rs;
                rs = sh[i][ns[i]-1];
                for (int k = 7; k > 0; k--) sh[i][k] = sh[i][k-1];
                sh[i][0] = int'(req_async);
                m_abort[i] = 0;
                if (!m_busy[i]) begin
                    if (rs != 0) begin m_busy[i] = 1; m_age[i] = 0; end
                end else if (m_age[i] < sp[i]) begin
                    if (rs == 0) begin m_busy[i] = 0; m_abort[i] = 1; end
                    else m_age[i]++;
                end else if (m_age[i] == sp[i]) begin
                    m_age[i]++;
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << cw[i]);
                end else begin
                    if (rs == 0) m_busy[i] = 0;
                    else m_age[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] cobs;
        for (int i = 0; i < 3; i++) begin
            cobs = (i == 0) ? 32'(cnt_a) : (i == 1) ? 32'(cnt_b) : 32'(cnt_c);
            chk($sformatf("sel%0d", i), 32'(sel_w[i]), 32'(m_busy[i] && m_age[i] == sp[i]));
            chk($sformatf("en%0d", i), 32'(en_w[i]), 32'(m_busy[i] && m_age[i] == sp[i] + 1));
            chk($sformatf("ack%0d", i), 32'(ack_w[i]), 32'(m_busy[i] && m_age[i] > sp[i]));
            chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_busy[i]));
            chk($sformatf("abort%0d", i), 32'(abort_w[i]), 32'(m_abort[i]));
            chk($sformatf("cnt%0d", i), cobs, 32'(m_cnt[i]));
            sel_seen[i] += int'(sel_w[i]);
            en_seen[i]  += int'(en_w[i]);
            ab_seen[i]  += int'(abort_w[i]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 3; i++) begin sel_seen[i] = 0; en_seen[i] = 0; ab_seen[i] = 0; end
    endtask

    initial begin
        int n;
        logic [1:0] exp_cnt[5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        RST = 1'b0; req_async = 1'b0; src_bus = 8'hA5;
        for (int i = 0; i < 3; i++) for (int k = 0; k < 8; k++) sh[i][k] = 0;
        tick(); tick();
        chk("rst.busy", 32'(busy_w[0]), 32'd0);
        chk("rst.cnt", 32'(cnt_a), 32'd0);

        // Capture latency and release timing.
        RST = 1'b1; req_async = 1'b1; clear_seen();
        tick(); tick();
        chk("t1.sel_e2", 32'(sel_w[0]), 32'd0);
        tick();
        chk("t4.sel_e3", 32'(sel_w[2]), 32'd1);
        tick();
        chk("t1.sel_e4", 32'(sel_w[0]), 32'd1);
        chk("t4.en_e4", 32'(en_w[2]), 32'd1);
        chk("t4.ack_e4", 32'(ack_w[2]), 32'd1);
        tick();
        chk("t1.en_e5", 32'(en_w[0]), 32'd1);
        chk("t1.ack_e5", 32'(ack_w[0]), 32'd1);
        chk("t1.cnt_e5", 32'(cnt_a), 32'd1);
        chk("t1.bus_e5", 32'(bus_q), 32'hA5);
        src_bus = 8'h5A;
        tick();
        chk("t1.en_e6", 32'(en_w[0]), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        req_async = 1'b0;
        tick(); tick();
        chk("t2.ack_hold", 32'(ack_w[0]), 32'd1);
        tick();
        chk("t2.ack_fall", 32'(ack_w[0]), 32'd0);
        chk("t2.busy", 32'(busy_w[0]), 32'd0);
        chk("t2.sel_once", 32'(sel_seen[0]), 32'd1);
        chk("t2.en_once", 32'(en_seen[0]), 32'd1);
        for (int k = 0; k < 3; k++) tick();

        // Short request aborts the long-settle instance.
        clear_seen();
        req_async = 1'b1; tick(); tick();
        req_async = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("t3.abort_cnt", 32'(ab_seen[1]), 32'd1);
        chk("t3.sel_cnt", 32'(sel_seen[1]), 32'd0);
        chk("t3.ack_off", 32'(ack_w[1]), 32'd0);

        // Reset during ACK, then recapture with req still high.
        req_async = 1'b1; n = 0;
        while (ack_w[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5.reach_ack", 32'(ack_w[0]), 32'd1);
        RST = 1'b0; clear_seen();
        tick();
        chk("t5.ack_rst", 32'(ack_w[0]), 32'd0);
        chk("t5.cnt_rst", 32'(cnt_a), 32'd0);
        chk("t5.abort_rst", 32'(ab_seen[0] + ab_seen[1] + ab_seen[2]), 32'd0);
        RST = 1'b1; n = 0;
        while (sel_w[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5.sel_latency", 32'(n), 32'd4);
        req_async = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        // Counter wrap on a 2-bit counter.
        RST = 1'b0; tick(); RST = 1'b1;
        for (int h = 0; h < 5; h++) begin
            clear_seen();
            req_async = 1'b1;
            for (int k = 0; k < 8; k++) tick();
            req_async = 1'b0;
            for (int k = 0; k < 5; k++) tick();
            chk($sformatf("t6.cnt%0d", h), 32'(cnt_b), 32'(exp_cnt[h]));
            chk($sformatf("t6.sel%0d", h), 32'(sel_seen[1]), 32'd1);
            chk($sformatf("t6.en%0d", h), 32'(en_seen[1]), 32'd1);
        end

        // Randomised req levels with occasional reset.
        for (int s = 0; s < 40; s++) begin
            RST = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            req_async = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
                tick();
                RST = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
